// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load handshake and framing strobes.
// Words stream back-to-back when a new word is offered during the last-bit cycle.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             stall,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;
    logic             accept;
    logic [WIDTH-1:0] sr_shifted;

    assign load_ready = !clr && !stall && (state_q == S_IDLE || cnt_q == LAST);
    assign accept     = load_valid && load_ready;
    assign busy       = (state_q == S_SHIFT);

    assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            if (state_q == S_SHIFT && cnt_q != LAST) begin
                sr_d  = sr_shifted;
                cnt_d = cnt_q + CW'(1);
            end else if (accept) begin
                sr_d    = din;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end else begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
        // Outputs are registered copies of the next state, so a stall holds them too.
        sout_valid_d = (state_d == S_SHIFT);
        sout_d       = sout_valid_d & (MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0]);
        done_d       = sout_valid_d && (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a word/bit-index reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] din;
    logic         load_valid;
    logic         stall;
    logic         rdy_m, sout_m, sv_m, done_m, busy_m;
    logic         rdy_l, sout_l, sv_l, done_l, busy_l;

    int checks = 0;
    int fails  = 0;

    // Reference model: word being sent, index of the bit on the line, active flag.
    logic [W-1:0] word;
    int           idx;
    bit           active;

    logic [7:0] q_m, q_l;
    int         valid_cnt, done_cycles;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .clr(clr), .din(din), .load_valid(load_valid), .load_ready(rdy_m),
        .stall(stall), .sout(sout_m), .sout_valid(sv_m), .done(done_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .clr(clr), .din(din), .load_valid(load_valid), .load_ready(rdy_l),
        .stall(stall), .sout(sout_l), .sout_valid(sv_l), .done(done_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic eb_m, eb_l, edone;
        eb_m  = active ? word[W-1-idx] : 1'b0;
        eb_l  = active ? word[idx] : 1'b0;
        edone = active && (idx == W - 1);
        chk("sout_msb", {7'd0, sout_m}, {7'd0, eb_m});
        chk("sout_lsb", {7'd0, sout_l}, {7'd0, eb_l});
        chk("sout_valid_msb", {7'd0, sv_m}, {7'd0, active});
        chk("sout_valid_lsb", {7'd0, sv_l}, {7'd0, active});
        chk("done_msb", {7'd0, done_m}, {7'd0, edone});
        chk("done_lsb", {7'd0, done_l}, {7'd0, edone});
        chk("busy_msb", {7'd0, busy_m}, {7'd0, active});
        chk("busy_lsb", {7'd0, busy_l}, {7'd0, active});
    endtask

    // One clock cycle: drive inputs, check ready, clock, advance model, check outputs.
    task automatic step(input logic [W-1:0] d, input logic lv, input logic st);
        logic exp_rdy, acc;
        din        = d;
        load_valid = lv;
        stall      = st;
        #1;
        exp_rdy = !st && (!active || idx == W - 1);
        chk("load_ready_msb", {7'd0, rdy_m}, {7'd0, exp_rdy});
        chk("load_ready_lsb", {7'd0, rdy_l}, {7'd0, exp_rdy});
        acc = lv && exp_rdy;
        @(posedge clk);
        if (!st) begin
            if (active && idx < W - 1) begin
                idx++;
            end else if (acc) begin
                word   = d;
                idx    = 0;
                active = 1'b1;
            end else begin
                active = 1'b0;
                idx    = 0;
            end
        end
        #1;
        check_outs();
        if (sv_m) begin
            q_m = {q_m[6:0], sout_m};
            valid_cnt++;
        end
        if (sv_l) q_l = {q_l[6:0], sout_l};
        if (done_m) done_cycles++;
    endtask

    task automatic do_clr();
        clr        = 1'b1;
        load_valid = 1'b1;
        stall      = 1'b0;
        #1;
        active = 1'b0;
        idx    = 0;
        check_outs();
        chk("clr_ready_msb", {7'd0, rdy_m}, 8'd0);
        chk("clr_ready_lsb", {7'd0, rdy_l}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        clr        = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic clear_capture();
        q_m         = '0;
        q_l         = '0;
        valid_cnt   = 0;
        done_cycles = 0;
    endtask

    initial begin
        clr        = 1'b1;
        din        = '0;
        load_valid = 1'b0;
        stall      = 1'b0;
        word       = '0;
        idx        = 0;
        active     = 1'b0;
        clear_capture();

        // Reset state
        #2;
        check_outs();
        chk("reset_ready", {7'd0, rdy_m}, 8'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Single word
        clear_capture();
        step(4'b1011, 1'b1, 1'b0);
        repeat (5) step(4'b0000, 1'b0, 1'b0);
        chk("single_q_msb", q_m, 8'h0B);
        chk("single_q_lsb", q_l, 8'h0D);
        chk("single_valid_cnt", 8'(valid_cnt), 8'd4);
        chk("single_done_cnt", 8'(done_cycles), 8'd1);

        // Back-to-back streaming
        clear_capture();
        step(4'b1100, 1'b1, 1'b0);
        repeat (4) step(4'b0110, 1'b1, 1'b0);
        repeat (3) step(4'b0110, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        chk("b2b_q_msb", q_m, 8'b1100_0110);
        chk("b2b_q_lsb", q_l, 8'b0011_0110);
        chk("b2b_valid_cnt", 8'(valid_cnt), 8'd8);
        chk("b2b_done_cnt", 8'(done_cycles), 8'd2);

        // Stall during bit 2, then again on the last bit with a load offered
        clear_capture();
        step(4'b1001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        repeat (2) step(4'b0000, 1'b0, 1'b0);
        chk("stall_valid_cnt", 8'(valid_cnt), 8'd7);
        chk("stall_done_cycles", 8'(done_cycles), 8'd2);

        // Reset mid-word, then a fresh word
        clear_capture();
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        do_clr();
        clear_capture();
        step(4'b0101, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b0, 1'b0);
        chk("postclr_q_msb", q_m, 8'h05);
        chk("postclr_q_lsb", q_l, 8'h0A);
        chk("postclr_done_cnt", 8'(done_cycles), 8'd1);

        // Load pulsed mid-word is ignored
        clear_capture();
        step(4'b1010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        repeat (5) step(4'b0000, 1'b0, 1'b0);
        chk("ignore_q_msb", q_m, 8'h0A);
        chk("ignore_q_lsb", q_l, 8'h05);
        chk("ignore_valid_cnt", 8'(valid_cnt), 8'd4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(49) == 0) begin
                do_clr();
            end else begin
                step(W'($urandom), ($urandom_range(2) != 0), ($urandom_range(3) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
